// File: rtl/uart_rx.sv
// uart_rx: bus-attached 8N1 UART receiver.
// A 2-flop synchroniser feeds a mid-bit sampling FSM. Received bytes land in a
// small FIFO that is read through a single-cycle device bus. A level interrupt
// is raised while data is pending and the interrupt is enabled.
module uart_rx #(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int RxFifoDepth    = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    input  logic        uart_rx_i,
    output logic        uart_rx_irq_o
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int CntW         = $clog2(ClocksPerBit);
    localparam int PtrW         = $clog2(RxFifoDepth);

    localparam logic [CntW-1:0] CNT_FULL = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] CNT_HALF = CntW'(ClocksPerBit / 2 - 1);
    localparam logic [CntW-1:0] CNT_ZERO = {CntW{1'b0}};
    localparam logic [CntW-1:0] CNT_ONE  = {{(CntW-1){1'b0}}, 1'b1};
    localparam logic [PtrW:0]   PTR_ONE  = {{PtrW{1'b0}}, 1'b1};
    localparam logic [PtrW:0]   PTR_ZERO = {(PtrW+1){1'b0}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam logic [1:0] REG_RXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // Line synchroniser and receive FSM state
    logic            rx_meta_r;
    logic            rx_sync_r;
    logic [2:0]      state_r;
    logic [CntW-1:0] cnt_r;
    logic [2:0]      idx_r;
    logic [7:0]      shift_r;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]      mem_r [RxFifoDepth];
    logic [PtrW:0]   wr_ptr_r;
    logic [PtrW:0]   rd_ptr_r;

    // Control/status and bus response registers
    logic            overflow_r;
    logic            frame_err_r;
    logic            irq_en_r;
    logic            irq_r;
    logic            rvalid_r;
    logic [31:0]     rdata_r;

    // Combinational helpers
    logic            empty_s;
    logic            full_s;
    logic            stop_sample_s;
    logic            push_s;
    logic            frame_set_s;
    logic            rd_req_s;
    logic            wr_req_s;
    logic            pop_s;
    logic            do_push_s;
    logic            overflow_set_s;
    logic            status_wr_s;
    logic            ctrl_wr_s;
    logic [31:0]     rdata_s;
    logic            unused_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[PtrW] != rd_ptr_r[PtrW]) &&
                     (wr_ptr_r[PtrW-1:0] == rd_ptr_r[PtrW-1:0]);

    assign stop_sample_s = (state_r == ST_STOP) && (cnt_r == CNT_ZERO);
    assign push_s        = stop_sample_s & rx_sync_r;
    assign frame_set_s   = stop_sample_s & ~rx_sync_r;

    assign rd_req_s    = device_req_i & ~device_we_i;
    assign wr_req_s    = device_req_i & device_we_i;
    assign pop_s       = rd_req_s & (device_addr_i[3:2] == REG_RXDATA) & ~empty_s;
    assign status_wr_s = wr_req_s & (device_addr_i[3:2] == REG_STATUS);
    assign ctrl_wr_s   = wr_req_s & (device_addr_i[3:2] == REG_CTRL);

    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle
    assign do_push_s      = push_s & (~full_s | pop_s);
    assign overflow_set_s = push_s & full_s & ~pop_s;

    // Byte enables and undecoded address/data bits are intentionally ignored
    assign unused_s = ^{device_be_i, device_addr_i[31:4], device_addr_i[1:0],
                        device_wdata_i[31:4], device_wdata_i[1]};

    // Two-flop synchroniser for the asynchronous serial line (idles high)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx_i;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM: qualify start at mid-bit, sample data LSB first, check stop
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r) begin
                        state_r <= ST_START;
                        cnt_r   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (!rx_sync_r) begin
                            state_r <= ST_DATA;
                            cnt_r   <= CNT_FULL;
                            idx_r   <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;   // glitch, not a real start bit
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_ZERO) begin
                        shift_r[idx_r] <= rx_sync_r;
                        cnt_r          <= CNT_FULL;
                        if (idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            idx_r <= idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= rx_sync_r ? ST_IDLE : ST_BREAK;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line so it cannot start a bogus frame
                    if (rx_sync_r) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointer update; pushes and pops are independent
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // FIFO storage write; contents are only observable through valid pointers
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[PtrW-1:0]] <= shift_r;
        end
    end

    // Sticky error flags: W1C clear, a same-cycle hardware set wins
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overflow_r  <= overflow_set_s |
                           (overflow_r & ~(status_wr_s & device_wdata_i[2]));
            frame_err_r <= frame_set_s |
                           (frame_err_r & ~(status_wr_s & device_wdata_i[3]));
        end
    end

    // Control register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_r <= 1'b0;
        end else if (ctrl_wr_s) begin
            irq_en_r <= device_wdata_i[0];
        end
    end

    // Read data mux for the addressed register
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (device_addr_i[3:2])
            REG_RXDATA: begin
                if (empty_s) begin
                    rdata_s = 32'h0000_0000;
                end else begin
                    rdata_s = {24'h00_0000, mem_r[rd_ptr_r[PtrW-1:0]]};
                end
            end
            REG_STATUS: rdata_s = {28'h000_0000, frame_err_r, overflow_r, full_s, empty_s};
            REG_CTRL:   rdata_s = {31'h0000_0000, irq_en_r};
            default:    rdata_s = 32'h0000_0000;
        endcase
    end

    // Registered bus response; writes and idle cycles return zero data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
        end else begin
            rvalid_r <= device_req_i;
            rdata_r  <= rd_req_s ? rdata_s : 32'h0000_0000;
        end
    end

    // Level interrupt while enabled and data is pending
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_en_r & ~empty_s;
        end
    end

    assign device_rvalid_o = rvalid_r;
    assign device_rdata_o  = rdata_r;
    assign uart_rx_irq_o   = irq_r;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rx;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx #(
        .ClockFrequency(1_600_000),
        .BaudRate      (100_000),
        .RxFifoDepth   (8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .uart_rx_i      (rx),
        .uart_rx_irq_o  (irq)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_read(input logic [1:0] idx, output logic [31:0] data);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h8000_4000 + {28'h0, idx, 2'b00};
        @(negedge clk);
        req  = 1'b0;
        check_eq("rd_rvalid", {31'h0, rvalid}, 32'h1);
        data = rdata;
    endtask

    task automatic read_check(input string tag, input logic [1:0] idx, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(idx, d);
        check_eq(tag, d, exp);
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
        req   = 1'b1;
        we    = 1'b1;
        addr  = 32'h8000_4000 + {28'h0, idx, 2'b00};
        wdata = data;
        @(negedge clk);
        req   = 1'b0;
        we    = 1'b0;
        wdata = 32'h0;
        check_eq("wr_rvalid", {31'h0, rvalid}, 32'h1);
        check_eq("wr_rdata", rdata, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = 32'h0;
        we    = 1'b0;
        be    = 4'hF;
        wdata = 32'h0;
        rx    = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check_eq("rst_rdata", rdata, 32'h0);
        check_eq("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        read_check("rst_status", 2'd1, 32'h1);
        read_check("rst_ctrl", 2'd2, 32'h0);

        // Single byte 0xA5
        send_byte(8'hA5);
        repeat (2) @(negedge clk);
        read_check("a5_status", 2'd1, 32'h0);
        read_check("a5_data", 2'd0, 32'h0000_00A5);
        read_check("a5_status_after", 2'd1, 32'h1);
        read_check("empty_rxdata", 2'd0, 32'h0);

        // 6-cycle glitch: false start, nothing queued
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        read_check("glitch_status", 2'd1, 32'h1);

        // 0x3C with stop bit held low for 20 bit times
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = (8'h3C >> i) & 8'h01;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b0;
        repeat (40) @(negedge clk);
        read_check("brk_status_low", 2'd1, 32'h9);
        repeat (CPB * 20 - 41) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        read_check("brk_status_high", 2'd1, 32'h9);
        bus_write(2'd1, 32'h8);
        read_check("brk_w1c", 2'd1, 32'h1);

        // Overflow: 9 bytes into an 8-deep FIFO
        for (int i = 0; i < 9; i++) begin
            send_byte(8'(i));
        end
        repeat (2) @(negedge clk);
        read_check("ovf_status", 2'd1, 32'h6);
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("ovf_data%0d", i), 2'd0, 32'(i));
        end
        read_check("ovf_data_empty", 2'd0, 32'h0);
        read_check("ovf_status_after", 2'd1, 32'h5);
        bus_write(2'd1, 32'h4);
        read_check("ovf_w1c", 2'd1, 32'h1);

        // Interrupt timing: stop sample lands on the 155th rising edge after
        // the start-bit edge; empty falls there and irq follows one cycle later.
        bus_write(2'd2, 32'h1);
        read_check("ctrl_set", 2'd2, 32'h1);
        check_eq("irq_idle", {31'h0, irq}, 32'h0);
        fork
            send_byte(8'h55);
            begin
                repeat (155) @(negedge clk);
                check_eq("irq_before", {31'h0, irq}, 32'h0);
                @(negedge clk);
                check_eq("irq_rise", {31'h0, irq}, 32'h1);
            end
        join
        read_check("irq_data", 2'd0, 32'h0000_0055);
        check_eq("irq_hold", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check_eq("irq_fall", {31'h0, irq}, 32'h0);

        bus_write(2'd2, 32'h0);
        send_byte(8'h66);
        repeat (4) @(negedge clk);
        check_eq("irq_disabled", {31'h0, irq}, 32'h0);
        read_check("dis_data", 2'd0, 32'h0000_0066);

        // Reset in the middle of data bit 4, held until the frame ends
        bus_write(2'd2, 32'h1);
        send_byte(8'h11);
        repeat (4) @(negedge clk);
        check_eq("pre_rst_irq", {31'h0, irq}, 32'h1);
        fork
            send_byte(8'h99);
            begin
                repeat (CPB * 5 + 8) @(negedge clk);
                rst_n = 1'b0;
                repeat (2) @(negedge clk);
                req  = 1'b1;
                addr = 32'h8000_4004;
                @(negedge clk);
                req  = 1'b0;
                check_eq("mid_rst_rvalid", {31'h0, rvalid}, 32'h0);
                check_eq("mid_rst_rdata", rdata, 32'h0);
                check_eq("mid_rst_irq", {31'h0, irq}, 32'h0);
            end
        join
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        read_check("post_rst_status", 2'd1, 32'h1);
        read_check("post_rst_ctrl", 2'd2, 32'h0);
        check_eq("post_rst_irq", {31'h0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
